// File: rtl/game_pkg.sv
// Shared types and constants for the memory-game symbol generator.
// SEED_CAPTURE_EN (optional) is consumed by simon_sequence_gen.
package game_pkg;

  typedef logic [1:0] sym_t;

  localparam int          GAME_DEPTH        = 100;
  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN1,
    ST_GEN2
  } gen_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  // An all-zero Galois LFSR is stuck forever.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/simon_sequence_gen_lfsr16.sv
// 16-bit right-shift Galois LFSR with load and zero-seed substitution.
// Load has priority over step; bit_o is the bit emitted by the next step.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        step,
  output logic [15:0] state_o,
  output logic        bit_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed_fix(load_value);
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= seed_fix(SEED);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign bit_o   = state_q[0];

endmodule

// File: rtl/simon_sequence_gen.sv
// Pseudo-random 2-bit symbol sequence store for the four-key memory game.
// Define SEED_CAPTURE_EN to seed each game from a free-running counter.
module simon_sequence_gen
  import game_pkg::*;
#(
  parameter int          DEPTH = GAME_DEPTH,
  parameter logic [15:0] SEED  = LFSR_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       extend,
  input  logic [7:0] rd_idx,
  output logic [1:0] rd_sym,
  output logic [7:0] length,
  output logic       busy,
  output logic       done,
  output logic       full
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  gen_state_e  state_q;
  logic [7:0]  length_q;
  logic        busy_q;
  logic        done_q;
  logic        full_q;
  logic        msb_q;
  sym_t        rd_sym_q;
  sym_t        store_q [DEPTH];

  logic [15:0] seed_val;
  logic [15:0] lfsr_q;
  logic        lfsr_bit;
  logic        lfsr_step;
  logic        unused_lfsr;
  sym_t        sym_d;
  logic        wr_en;

`ifdef SEED_CAPTURE_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign seed_val = cnt_q;
`else
  assign seed_val = SEED;
`endif

  assign lfsr_step = !start && (state_q != ST_IDLE);

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start),
    .load_value(seed_val),
    .step      (lfsr_step),
    .state_o   (lfsr_q),
    .bit_o     (lfsr_bit)
  );

  assign unused_lfsr = ^lfsr_q;

  assign sym_d = {msb_q, lfsr_bit};
  assign wr_en = !start && (state_q == ST_GEN2)
              && (length_q < DEPTH_L);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      length_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      msb_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q  <= ST_GEN1;
        length_q <= 8'd0;
        full_q   <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (extend && !full_q) begin
              state_q <= ST_GEN1;
              busy_q  <= 1'b1;
            end
          end
          ST_GEN1: begin
            msb_q   <= lfsr_bit;
            state_q <= ST_GEN2;
          end
          ST_GEN2: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (length_q < DEPTH_L) begin
              length_q <= length_q + 8'd1;
            end
            full_q <= (length_q >= DEPTH_L - 8'd1);
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Store needs no reset: every read is gated by length.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      store_q[length_q[AW-1:0]] <= sym_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_sym_q <= 2'b00;
    end else if (rd_idx < length_q) begin
      rd_sym_q <= store_q[rd_idx[AW-1:0]];
    end else begin
      rd_sym_q <= 2'b00;
    end
  end

  assign rd_sym = rd_sym_q;
  assign length = length_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign full   = full_q;

endmodule

// File: tb/tb_simon_sequence_gen.sv
// Scoreboard bench for simon_sequence_gen (default DEPTH/SEED).
// With SEED_CAPTURE_EN defined it also exercises counter seeding.
module tb_simon_sequence_gen;

  localparam int          DEPTH = 100;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       extend = 1'b0;
  logic [7:0] rd_idx = 8'd0;
  logic [1:0] rd_sym;
  logic [7:0] length;
  logic       busy;
  logic       done;
  logic       full;

  simon_sequence_gen #(
    .DEPTH(DEPTH),
    .SEED (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .extend(extend),
    .rd_idx(rd_idx),
    .rd_sym(rd_sym),
    .length(length),
    .busy  (busy),
    .done  (done),
    .full  (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    logic [1:0] sym;
    int         at;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc    = 0;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_done = 0;
  int          m_len  = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [1:0]  m_store [256];

  always @(posedge clk) cyc <= cyc + 1;

`ifdef SEED_CAPTURE_EN
  logic [15:0] cnt_m = 16'h0000;
  always @(posedge clk) cnt_m <= !rst_n ? 16'h0000 : cnt_m + 16'h0001;
`endif

  function automatic logic [15:0] m_seed();
    logic [15:0] s;
`ifdef SEED_CAPTURE_EN
    s = cnt_m;
`else
    s = SEED;
`endif
    return (s == 16'h0000) ? 16'hACE1 : s;
  endfunction

  function automatic logic m_bit();
    logic b;
    b = m_lfsr[0];
    m_lfsr = b ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    return b;
  endfunction

  // sampling edge "when"; done expected two edges later
  task automatic push_sym(input int when);
    logic [1:0] s;
    s[1] = m_bit();
    s[0] = m_bit();
    m_len = m_len + 1;
    m_store[m_len-1] = s;
    sb_q.push_back('{m_len, s, when + 2});
  endtask

  task automatic model_start(input int when);
    m_lfsr = m_seed();
    m_len  = 0;
    sb_q.delete();
    push_sym(when);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      n_done = n_done + 1;
      n_cmp  = n_cmp + 1;
      if (sb_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_done: got done at cycle %0d, required none",
                 cyc);
      end else begin
        e = sb_q.pop_front();
        if (length !== 8'(e.len) || cyc !== e.at) begin
          n_err = n_err + 1;
          $display("FAIL done_commit: got len %0d at cyc %0d, required len %0d at cyc %0d",
                   length, cyc, e.len, e.at);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((busy !== 1'b0 || sb_q.size() != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (i >= budget) begin
      n_err++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d, required idle",
               busy, sb_q.size());
    end
  endtask

  task automatic read_check(input logic [7:0] idx, input logic [1:0] exp,
                            input string name, output logic [1:0] got);
    @(negedge clk);
    rd_idx = idx;
    @(negedge clk);
    got = rd_sym;
    n_cmp++;
    if (rd_sym !== exp) begin
      n_err++;
      $display("FAIL %s: idx %0d got %b, required %b", name, idx, rd_sym, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    model_start(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_extend();
    @(negedge clk);
    extend = 1'b1;
    if (m_len < DEPTH) push_sym(cyc + 1);
    @(negedge clk);
    extend = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({length, busy, done, full, rd_sym} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state: got len=%0d busy=%b done=%b full=%b sym=%b, required all 0",
               length, busy, done, full, rd_sym);
    end
    rst_n = 1'b1;
    m_len = 0;
    sb_q.delete();
  endtask

  task automatic test_start_extend();
    logic [1:0] g;
    logic [1:0] e0;
    logic [1:0] e1;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_k1: got busy=%b done=%b, required 1 0", busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || length !== 8'd0) begin
      n_err++;
      $display("FAIL busy_k2: got busy=%b done=%b len=%0d, required 1 0 0",
               busy, done, length);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1 || length !== 8'd1) begin
      n_err++;
      $display("FAIL done_k3: got busy=%b done=%b len=%0d, required 0 1 1",
               busy, done, length);
    end
    wait_idle(10);
    pulse_extend();
    wait_idle(10);
`ifdef SEED_CAPTURE_EN
    e0 = m_store[0];
    e1 = m_store[1];
`else
    e0 = 2'b10;
    e1 = 2'b00;
`endif
    read_check(8'd0, e0, "sym0", g);
    read_check(8'd1, e1, "sym1", g);
    read_check(8'd2, 2'b00, "gated_idx2", g);
    n_cmp++;
    if (length !== 8'd2) begin
      n_err++;
      $display("FAIL len_after_extend: got %0d, required 2", length);
    end
  endtask

  task automatic test_saturate();
    int d0;
    int k;
    logic [1:0] g;
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    model_start(k);
    for (int i = 1; i < DEPTH; i++) push_sym(k + 3 * i);
    @(negedge clk);
    start  = 1'b0;
    extend = 1'b1;
    repeat (400) @(negedge clk);
    extend = 1'b0;
    n_cmp++;
    if (n_done - d0 != DEPTH || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sat_done_count: got %0d pending %0d, required %0d pending 0",
               n_done - d0, sb_q.size(), DEPTH);
    end
    n_cmp++;
    if (length !== 8'(DEPTH) || full !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL sat_len_full: got len=%0d full=%b busy=%b, required %0d 1 0",
               length, full, busy, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) read_check(8'(i), m_store[i], "sat_sym", g);
    read_check(8'(DEPTH), 2'b00, "sat_past_end", g);
    read_check(8'd255, 2'b00, "sat_idx255", g);
  endtask

  task automatic test_start_plus_extend();
    logic [1:0] g;
    @(negedge clk);
    start  = 1'b1;
    extend = 1'b1;
    model_start(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    extend = 1'b0;
    wait_idle(10);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (length !== 8'd1 || full !== 1'b0) begin
      n_err++;
      $display("FAIL single_symbol: got len=%0d full=%b, required 1 0", length, full);
    end
    read_check(8'd0, m_store[0], "spe_sym0", g);
  endtask

  task automatic test_restart();
    logic [1:0] g;
    logic [1:0] e0;
    pulse_start();
    wait_idle(10);
    repeat (4) begin
      pulse_extend();
      wait_idle(10);
    end
    n_cmp++;
    if (length !== 8'd5) begin
      n_err++;
      $display("FAIL len5: got %0d, required 5", length);
    end
    @(negedge clk);
    extend = 1'b1;
    @(negedge clk);
    extend = 1'b0;
    start  = 1'b1;
    model_start(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (length !== 8'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_clear: got len=%0d busy=%b, required 0 1", length, busy);
    end
    wait_idle(10);
    n_cmp++;
    if (length !== 8'd1) begin
      n_err++;
      $display("FAIL restart_len: got %0d, required 1", length);
    end
`ifdef SEED_CAPTURE_EN
    e0 = m_store[0];
`else
    e0 = 2'b10;
`endif
    read_check(8'd0, e0, "restart_sym0", g);
    read_check(8'd1, 2'b00, "restart_gated1", g);
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    pulse_start();
    wait_idle(10);
    @(negedge clk);
    extend = 1'b1;
    @(negedge clk);
    extend = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    m_len = 0;
    sb_q.delete();
    @(negedge clk);
    n_cmp++;
    if (length !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got len=%0d busy=%b done=%b, required 0 0 0",
               length, busy, done);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    read_check(8'd0, 2'b00, "reset_mid_idx0", g);
  endtask

`ifdef SEED_CAPTURE_EN
  task automatic test_seed_capture();
    logic [1:0] a [8];
    logic [1:0] b [8];
    logic [1:0] g;
    int diff = 0;
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    model_start(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle(10);
    repeat (7) begin
      pulse_extend();
      wait_idle(10);
    end
    read_check(8'd0, 2'b10, "cap0_sym0", g);
    read_check(8'd1, 2'b00, "cap0_sym1", g);
    for (int i = 0; i < 8; i++) read_check(8'(i), m_store[i], "cap0_stream", a[i]);
    repeat (37) @(negedge clk);
    pulse_start();
    wait_idle(10);
    repeat (7) begin
      pulse_extend();
      wait_idle(10);
    end
    for (int i = 0; i < 8; i++) read_check(8'(i), m_store[i], "cap1_stream", b[i]);
    for (int i = 0; i < 8; i++) if (a[i] !== b[i]) diff++;
    n_cmp++;
    if (diff == 0) begin
      n_err++;
      $display("FAIL capture_differs: got %0d differing symbols, required >0", diff);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start_extend();
    test_saturate();
    test_start_plus_extend();
    test_restart();
    test_reset_mid();
`ifdef SEED_CAPTURE_EN
    test_seed_capture();
`endif
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
